// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline-side inputs and sequencing outputs of the hazard controller
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             id_valid;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_uses_rn;
    logic             id_two_src;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             br_taken;
    logic             mem_busy;
    logic             freeze_pc;
    logic             freeze_ifid;
    logic             flush_ifid;
    logic             freeze_idex;
    logic             flush_idex;
    logic             freeze_back;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output id_valid, id_src1, id_src2, id_uses_rn, id_two_src, exe_dest, exe_wb_en,
               exe_mem_r_en, mem_dest, mem_wb_en, br_taken, mem_busy,
        input  freeze_pc, freeze_ifid, flush_ifid, freeze_idex, flush_idex, freeze_back,
               mem_timeout, stall_cnt, bubble_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_uses_rn, id_two_src, exe_dest, exe_wb_en,
               exe_mem_r_en, mem_dest, mem_wb_en, br_taken, mem_busy,
        output freeze_pc, freeze_ifid, flush_ifid, freeze_idex, flush_idex, freeze_back,
               mem_timeout, stall_cnt, bubble_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: freeze/flush sequencer with memory-wait timeout FSM and perf counters
module pipe_hazard_ctrl #(
    parameter int FWD_EN      = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input logic               clk,
    input logic               rst,
    pipe_hazard_ctrl_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    state_t           state;
    logic [15:0]      wait_cnt;
    logic [15:0]      wait_nxt;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] bubble_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic             hz1;
    logic             hz2;
    logic             exe_hit;
    logic             mem_hit;
    logic             hazard;
    logic             frz;
    logic             frz_o;
    logic             flush_o;
    logic             bubble_o;
    logic             to_hit;

    // Hazard detection and prioritised control; rst low masks every control output at once
    always_comb begin
        hz1      = bus.id_valid & bus.id_uses_rn;
        hz2      = bus.id_valid & bus.id_two_src;
        exe_hit  = bus.exe_wb_en & ((hz1 & (bus.id_src1 == bus.exe_dest)) | (hz2 & (bus.id_src2 == bus.exe_dest)));
        mem_hit  = bus.mem_wb_en & ((hz1 & (bus.id_src1 == bus.mem_dest)) | (hz2 & (bus.id_src2 == bus.mem_dest)));
        hazard   = (FWD_EN != 0) ? (exe_hit & bus.exe_mem_r_en) : (exe_hit | mem_hit);
        frz      = (state == ERR) | bus.mem_busy;
        frz_o    = rst & frz;
        flush_o  = rst & ~frz & bus.br_taken;
        bubble_o = rst & ~frz & ~bus.br_taken & hazard;
        wait_nxt = (state == RUN) ? 16'd1 : wait_cnt + 16'd1;
        to_hit   = wait_nxt == 16'(MEM_TIMEOUT);
    end

    assign bus.freeze_pc   = frz_o | bubble_o;
    assign bus.freeze_ifid = frz_o | bubble_o;
    assign bus.flush_ifid  = flush_o;
    assign bus.freeze_idex = frz_o;
    assign bus.flush_idex  = flush_o | bubble_o;
    assign bus.freeze_back = frz_o;
    assign bus.mem_timeout = mem_timeout;
    assign bus.stall_cnt   = stall_cnt;
    assign bus.bubble_cnt  = bubble_cnt;
    assign bus.flush_cnt   = flush_cnt;

    // Memory-wait timeout FSM (ERR is only left through reset) and saturating event counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
            stall_cnt   <= '0;
            bubble_cnt  <= '0;
            flush_cnt   <= '0;
        end else begin
            if (state != ERR && bus.mem_busy) begin
                wait_cnt <= wait_nxt;
                state    <= to_hit ? ERR : MEM_WAIT;
                if (to_hit) mem_timeout <= 1'b1;
            end else if (state == MEM_WAIT) begin
                state <= RUN;
            end
            if (bus.mem_busy && state != ERR && ~&stall_cnt) stall_cnt <= stall_cnt + 1'b1;
            if (bubble_o && ~&bubble_cnt) bubble_cnt <= bubble_cnt + 1'b1;
            if (flush_o && ~&flush_cnt) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
